// File: rtl/rv32_types.sv
// Shared types for the RV32 store path: memory op encodings, the store
// buffer entry layout and the machine word.
package rv32_types;

    typedef logic [31:0] rv32_word;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_SB   = 3'd1,
        MEM_SH   = 3'd2,
        MEM_SW   = 3'd3,
        MEM_LB   = 3'd4,
        MEM_LH   = 3'd5,
        MEM_LW   = 3'd6
    } mem_op_t;

    // Stored address is the word address; the byte offset lives in wstrb.
    typedef struct packed {
        logic [29:0] addr;
        rv32_word    wdata;
        logic [3:0]  wstrb;
    } store_entry_t;

    function automatic logic is_store_op(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/rv32_store_fix.sv
// Combinational store formatter: lane-replicates store data and builds byte
// strobes. Misalignment detection only when RV32_STORE_MISALIGN_TRAP_EN is defined.
module rv32_store_fix
    import rv32_types::*;
(
    input  mem_op_t    i_op,
    input  logic [1:0] i_addr_lo,
    input  rv32_word   i_data,
    output rv32_word   o_wdata,
    output logic [3:0] o_wstrb,
    output logic       o_is_store,
    output logic       o_misaligned
);

    always_comb begin
        o_wdata    = '0;
        o_wstrb    = 4'b0000;
        o_is_store = 1'b0;
        case (i_op)
            MEM_SB: begin
                o_wdata    = {4{i_data[7:0]}};
                o_wstrb    = 4'b0001 << i_addr_lo;
                o_is_store = 1'b1;
            end
            MEM_SH: begin
                o_wdata    = {2{i_data[15:0]}};
                o_wstrb    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_is_store = 1'b1;
            end
            MEM_SW: begin
                o_wdata    = i_data;
                o_wstrb    = 4'b1111;
                o_is_store = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RV32_STORE_MISALIGN_TRAP_EN
    assign o_misaligned = ((i_op == MEM_SH) && i_addr_lo[0]) ||
                          ((i_op == MEM_SW) && (i_addr_lo != 2'b00));
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/rv32_store_buffer.sv
// Store buffer: formats stores, queues them in a DEPTH-entry FIFO, drains them
// over a req/gnt port and flags load hazards. RV32_STORE_MISALIGN_TRAP_EN drops misaligned stores.
module rv32_store_buffer
    import rv32_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_st_valid,
    input  mem_op_t                      i_st_op,
    input  logic [31:0]                  i_st_addr,
    input  logic [31:0]                  i_st_data,
    output logic                         o_st_ready,
    output logic                         o_st_misaligned,
    input  logic                         i_ld_check_valid,
    input  logic [31:0]                  i_ld_check_addr,
    output logic                         o_ld_hazard,
    output logic                         o_mem_req,
    input  logic                         i_mem_gnt,
    output logic [31:0]                  o_mem_addr,
    output logic [31:0]                  o_mem_wdata,
    output logic [3:0]                   o_mem_wstrb,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    store_entry_t     r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    rv32_word     w_wdata;
    logic [3:0]   w_wstrb;
    logic         w_is_store;
    logic         w_misaligned;
    logic         w_full;
    logic         w_push;
    logic         w_pop;
    store_entry_t w_head;
    logic         w_unused_ld;

    rv32_store_fix u_fix (
        .i_op         (i_st_op),
        .i_addr_lo    (i_st_addr[1:0]),
        .i_data       (i_st_data),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_is_store   (w_is_store),
        .o_misaligned (w_misaligned)
    );

    // Byte offset of the load is irrelevant: the hazard compare is word-granular.
    assign w_unused_ld = ^i_ld_check_addr[1:0];

    assign w_full          = (r_count == CW'(DEPTH));
    assign o_st_ready      = !w_full;
    assign o_st_misaligned = i_st_valid && w_misaligned;
    assign o_empty         = (r_count == '0);
    assign o_count         = r_count;
    assign o_mem_req       = !o_empty;

    assign w_push = i_st_valid && o_st_ready && w_is_store && !w_misaligned;
    assign w_pop  = o_mem_req && i_mem_gnt;

    assign w_head      = r_mem[r_rd_ptr];
    assign o_mem_addr  = {w_head.addr, 2'b00};
    assign o_mem_wdata = w_head.wdata;
    assign o_mem_wstrb = w_head.wstrb;

    always_comb begin
        o_ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_mem[i].addr == i_ld_check_addr[31:2])) begin
                o_ld_hazard = 1'b1;
            end
        end
        o_ld_hazard = o_ld_hazard && i_ld_check_valid;
    end

    // Entry payload carries no reset; r_valid/r_count qualify it.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: i_st_addr[31:2], wdata: w_wdata, wstrb: w_wstrb};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Push and pop never target the same slot: push needs !full, pop needs !empty.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pop && (r_rd_ptr == PW'(i))) begin
                    r_valid[i] <= 1'b0;
                end else if (w_push && (r_wr_ptr == PW'(i))) begin
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_store_buffer.sv
// Directed bench for rv32_store_buffer with a drain-side scoreboard.
module tb_rv32_store_buffer;
    import rv32_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    mem_op_t     st_op = MEM_NONE;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ready;
    logic        st_misaligned;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_hazard;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        empty;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rv32_store_buffer #(.DEPTH(4)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_st_valid       (st_valid),
        .i_st_op          (st_op),
        .i_st_addr        (st_addr),
        .i_st_data        (st_data),
        .o_st_ready       (st_ready),
        .o_st_misaligned  (st_misaligned),
        .i_ld_check_valid (ld_valid),
        .i_ld_check_addr  (ld_addr),
        .o_ld_hazard      (ld_hazard),
        .o_mem_req        (mem_req),
        .i_mem_gnt        (mem_gnt),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .o_mem_wstrb      (mem_wstrb),
        .o_empty          (empty),
        .o_count          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.addr  = a;
        e.wdata = d;
        e.wstrb = s;
        sb.push_back(e);
    endtask

    // Every granted head entry must match the oldest expected store.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_gnt) begin
            if (sb.size() == 0) begin
                chk("spurious_req", 32'(mem_req), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("drain_addr", mem_addr, e.addr);
                chk("drain_wdata", mem_wdata, e.wdata);
                chk("drain_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
            end
        end
    end

    mem_op_t     t_op  [5];
    logic [31:0] t_addr[5];
    logic [31:0] t_data[5];
    logic [31:0] t_wd  [5];
    logic [3:0]  t_st  [5];

    initial begin
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // SB with grant held high
        mem_gnt = 1'b1;
        drive(MEM_SB, 32'h0000_1003, 32'hAABB_CCDD);
        #1;
        chk("sb_ready", 32'(st_ready), 32'd1);
        chk("no_fallthrough", 32'(mem_req), 32'd0);
        exp_push(32'h0000_1000, 32'hDDDD_DDDD, 4'b1000);
        tick();
        st_valid = 1'b0;
        chk("sb_req", 32'(mem_req), 32'd1);
        chk("sb_addr", mem_addr, 32'h0000_1000);
        chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
        chk("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
        tick();
        chk("sb_empty_after", 32'(empty), 32'd1);
        chk("sb_req_after", 32'(mem_req), 32'd0);

        // SH + SW with grant held low: head must hold
        mem_gnt = 1'b0;
        drive(MEM_SH, 32'h0000_2002, 32'h1234_5678);
        exp_push(32'h0000_2000, 32'h5678_5678, 4'b1100);
        tick();
        drive(MEM_SW, 32'h0000_2004, 32'hCAFE_F00D);
        exp_push(32'h0000_2004, 32'hCAFE_F00D, 4'b1111);
        tick();
        st_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_addr", mem_addr, 32'h0000_2000);
            chk("hold_wdata", mem_wdata, 32'h5678_5678);
            chk("hold_wstrb", 32'(mem_wstrb), 32'hC);
            chk("hold_count", 32'(count), 32'd2);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("hold_drained", 32'(empty), 32'd1);

        // Fill to DEPTH, then release
        for (int i = 0; i < 4; i++) begin
            drive(MEM_SW, 32'h0000_5000 + 32'(4 * i), 32'h100 + 32'(i));
            #1;
            chk("fill_ready", 32'(st_ready), 32'd1);
            exp_push(32'h0000_5000 + 32'(4 * i), 32'h100 + 32'(i), 4'b1111);
            tick();
        end
        drive(MEM_SW, 32'h0000_5010, 32'h500);
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_not_ready", 32'(st_ready), 32'd0);
        tick();
        chk("fifth_rejected", 32'(count), 32'd4);
        mem_gnt = 1'b1;
        #1;
        chk("gnt_cycle_count", 32'(count), 32'd4);
        chk("no_full_bypass", 32'(st_ready), 32'd0);
        tick();
        chk("after_pop_count", 32'(count), 32'd3);
        chk("after_pop_ready", 32'(st_ready), 32'd1);
        exp_push(32'h0000_5010, 32'h500, 4'b1111);
        tick();
        st_valid = 1'b0;
        chk("push_pop_count", 32'(count), 32'd3);
        tick();
        tick();
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("fill_drained", 32'(empty), 32'd1);

        // Load hazard compare
        drive(MEM_SW, 32'h0000_3008, 32'h11);
        exp_push(32'h0000_3008, 32'h11, 4'b1111);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_300B;
        #1;
        chk("haz_same_word", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h0000_300C;
        #1;
        chk("haz_next_word", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b0;
        ld_addr  = 32'h0000_3008;
        #1;
        chk("haz_no_valid", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_3100;
        drive(MEM_SW, 32'h0000_3100, 32'h22);
        #1;
        chk("haz_push_same_cycle", 32'(ld_hazard), 32'd0);
        exp_push(32'h0000_3100, 32'h22, 4'b1111);
        tick();
        st_valid = 1'b0;
        chk("haz_second_entry", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h0000_3008;
        mem_gnt = 1'b1;
        #1;
        chk("haz_during_grant", 32'(ld_hazard), 32'd1);
        tick();
        chk("haz_after_grant", 32'(ld_hazard), 32'd0);
        tick();
        mem_gnt  = 1'b0;
        ld_valid = 1'b0;
        #1;
        chk("haz_drained", 32'(empty), 32'd1);

        // Lane/strobe table with continuous grant; last row is a non-store op
        t_op[0] = MEM_SB; t_addr[0] = 32'h6001; t_data[0] = 32'h1234_565A; t_wd[0] = 32'h5A5A_5A5A; t_st[0] = 4'b0010;
        t_op[1] = MEM_SB; t_addr[1] = 32'h6002; t_data[1] = 32'h0000_00C3; t_wd[1] = 32'hC3C3_C3C3; t_st[1] = 4'b0100;
        t_op[2] = MEM_SB; t_addr[2] = 32'h6000; t_data[2] = 32'hFFFF_FF01; t_wd[2] = 32'h0101_0101; t_st[2] = 4'b0001;
        t_op[3] = MEM_SH; t_addr[3] = 32'h6000; t_data[3] = 32'hBEEF_1234; t_wd[3] = 32'h1234_1234; t_st[3] = 4'b0011;
        t_op[4] = MEM_LW; t_addr[4] = 32'h6004; t_data[4] = 32'h9999_9999; t_wd[4] = 32'h0;         t_st[4] = 4'b0000;
        mem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(t_op[i], t_addr[i], t_data[i]);
            if (i < 4) exp_push({t_addr[i][31:2], 2'b00}, t_wd[i], t_st[i]);
            tick();
        end
        drive(mem_op_t'(3'd7), 32'h6008, 32'h7777_7777);
        tick();
        st_valid = 1'b0;
        chk("nonstore_not_queued", 32'(count), 32'd0);
        mem_gnt = 1'b0;
        tick();

        // Asynchronous reset with pending entries
        drive(MEM_SW, 32'h0000_7000, 32'h70);
        tick();
        drive(MEM_SW, 32'h0000_7004, 32'h74);
        tick();
        st_valid = 1'b0;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        chk("pre_rst_count", 32'(count), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_ready", 32'(st_ready), 32'd1);
        tick();
        rst = 1'b0;
        mem_gnt = 1'b1;
        #1;
        chk("post_rst_req", 32'(mem_req), 32'd0);
        tick();
        chk("post_rst_req2", 32'(mem_req), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);
        mem_gnt = 1'b0;

        // Misaligned SW
        drive(MEM_SW, 32'h0000_4002, 32'h77);
`ifdef RV32_STORE_MISALIGN_TRAP_EN
        #1;
        chk("misal_flag", 32'(st_misaligned), 32'd1);
        chk("misal_ready", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        chk("misal_not_queued", 32'(count), 32'd0);
        chk("misal_empty", 32'(empty), 32'd1);
`else
        #1;
        chk("misal_flag_off", 32'(st_misaligned), 32'd0);
        exp_push(32'h0000_4000, 32'h77, 4'b1111);
        tick();
        st_valid = 1'b0;
        chk("misal_queued", 32'(count), 32'd1);
        chk("misal_addr", mem_addr, 32'h0000_4000);
        chk("misal_wstrb", 32'(mem_wstrb), 32'hF);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("misal_drained", 32'(empty), 32'd1);
`endif

        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32_store_buffer.md
Name: rv32_store_buffer

Overview:
- Write-side counterpart of the load path: accepts store requests from the memory stage and produces word-aligned write data with byte strobes.
- Queues stores in a small FIFO and drains them to the data memory port with a req/gnt handshake.
- Flags loads whose word address matches a pending store so the pipeline can stall instead of reading stale memory.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- st_valid  in  1  store request from memory stage
- st_op  in  mem_op_t  MEM_SB / MEM_SH / MEM_SW; any other value never enqueues
- st_addr  in  32  byte address
- st_data  in  32  raw rs2 value
- st_ready  out  1  buffer can accept this cycle
- st_misaligned  out  1  misaligned store flag (see Optional Feature)
- ld_check_valid  in  1  load in memory stage
- ld_check_addr  in  32  load byte address
- ld_hazard  out  1  load word matches a pending store
- mem_req  out  1  write request to data memory
- mem_gnt  in  1  memory accepts head entry
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_wdata  out  32  lane-replicated write data
- mem_wstrb  out  4  byte strobes
- empty  out  1  no pending stores
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (async, immediate): wr_ptr, rd_ptr and count = 0; mem_req = 0, empty = 1, st_ready = 1; entry contents undefined. Reset mid-drain discards all entries, including a request that has not yet been granted.
- Push when st_valid && st_ready && st_op is a store op; st_ready = !full.
  - No full-bypass: a pop in the same cycle does not raise st_ready.
- Store fix (combinational, pre-queue):
  - SB: wstrb = 1 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = data.
  - Stored address = {addr[31:2], 2'b00}.
- Drain:
  - mem_req = !empty; mem_addr/wdata/wstrb driven from the head entry.
  - Pop on mem_req && mem_gnt.
  - Outputs stay stable while mem_req is high and mem_gnt is low.
  - mem_gnt while empty is ignored.
- Latency: a store pushed in cycle N is visible on mem_req at N+1 at the earliest (registered FIFO, no fall-through).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: modulo DEPTH; full/empty derived from count.
- Hazard: ld_hazard = ld_check_valid && any valid entry with addr[31:2] == ld_check_addr[31:2]. Combinational, strobe-agnostic. An entry being granted in the current cycle still counts. A store being pushed in the same cycle does not count.
- count and empty are registered-state-derived, with no combinational path from st_valid.

Optional Feature:
- Macro: RV32_STORE_MISALIGN_TRAP_EN.
- Defined:
  - st_misaligned = st_valid && ((SH && addr[0]) || (SW && addr[1:0] != 0)).
  - A misaligned store is consumed when st_ready (the pipeline raises the exception) but never enqueued.
- Undefined:
  - st_misaligned tied 0.
  - SH ignores addr[0]; SW ignores addr[1:0]; all such stores are enqueued as if aligned.

Decomposition:
- rv32_types package:
  - mem_op_t store encodings
  - store_entry_t {addr[31:2], wdata, wstrb}
  - rv32_word
- Sub-module rv32_store_fix: purely combinational op/addr/data -> wdata/wstrb/misaligned, the mirror of the load fixer. FIFO and hazard compare live in the top.

Test Plan:
- SB addr 0x1003 data 0xAABBCCDD, gnt held high -> next cycle mem_req=1, mem_addr=0x1000, wstrb=4'b1000, wdata=0xDDDDDDDD; popped, empty=1 the following cycle.
- SH addr 0x2002 data 0x12345678, then SW addr 0x2004 data 0xCAFEF00D, gnt low 3 cycles -> head stable at 0x2000/0x56785678/4'b1100 for 3 cycles, count=2; then the two grants drain them in order.
- Push 4 stores with gnt=0 -> count=4, st_ready=0; 5th st_valid is not accepted. Assert gnt with st_valid still high: count stays 4 that cycle, and the 5th is accepted the cycle after.
- Pending SW at 0x3008; load check 0x300B -> ld_hazard=1; load check 0x300C -> 0. After its grant cycle, check 0x3008 -> 0.
- Assert rst while 2 entries pending and mem_req=1 -> mem_req=0, count=0, empty=1 without a clock edge; no grant consumed afterwards.
- With RV32_STORE_MISALIGN_TRAP_EN: SW addr 0x4002 -> st_misaligned=1, count unchanged. Without it: the same store is enqueued with mem_addr=0x4000, wstrb=4'b1111.
